// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned RF_W     = 8;
    localparam int unsigned RF_D     = 4;
    localparam int unsigned RF_DEPTH = 2 ** RF_D;

    // One W-bit reset value per register, entry 0 in the least significant slot.
    typedef logic [RF_DEPTH-1:0][RF_W-1:0] init_t;

    // R0 = 30, R2 = 5, every other register 0.
    localparam init_t DEFAULT_INIT = {{(RF_DEPTH - 3){8'h00}}, 8'h05, 8'h00, 8'h1E};

    // Extract field idx (each width bits wide) from a packed per-port vector.
    function automatic logic [31:0] port_field(input logic [127:0] vec,
                                               input int unsigned idx,
                                               input int unsigned width);
        logic [127:0] mask;
        mask = (128'd1 << width) - 128'd1;
        return 32'((vec >> (idx * width)) & mask);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with sticky double-reservation error flag.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned D       = RF_D,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            write_en,
    input  logic [D-1:0]    waddr,
    input  logic            resv_en,
    input  logic [D-1:0]    resv_addr,
    input  logic            err_clr,
    output logic [2**D-1:0] busy,
    output logic            resv_err
);

    logic [2**D-1:0] busy_d;
    logic            resv_ok;
    logic            err_set;
    logic            err_d;

    // A reserve of the hard-wired zero register is dropped entirely.
    assign resv_ok = resv_en && !(ZERO_R0 != 0 && resv_addr == '0);

    // Double reservation is only an error when no write retires the register this cycle.
    assign err_set = resv_ok && busy[resv_addr] && !(write_en && waddr == resv_addr);

    // Next busy vector: write retires, then a new reservation overrides it.
    always_comb begin
        busy_d = busy;
        if (write_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (resv_ok) begin
            busy_d[resv_addr] = 1'b1;
        end
    end

    // Sticky error: set has priority over clear.
    always_comb begin
        err_d = resv_err;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Scoreboard state; reset drops all pending reservations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            resv_err <= 1'b0;
        end else begin
            busy     <= busy_d;
            resv_err <= err_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file: NR combinational read ports with write bypass, one write port,
// and a busy scoreboard for reserving destinations of multi-cycle units.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned W       = RF_W,
    parameter int unsigned D       = RF_D,
    parameter int unsigned NR      = 2,
    parameter int unsigned ZERO_R0 = 0,
    parameter init_t       INIT    = '0
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic            WriteEn,
    input  logic [D-1:0]    Waddr,
    input  logic [W-1:0]    DataIn,
    input  logic [NR*D-1:0] Raddr,
    output logic [NR*W-1:0] DataOut,
    output logic [NR-1:0]   RdReady,
    input  logic            ResvEn,
    input  logic [D-1:0]    ResvAddr,
    output logic [2**D-1:0] Busy,
    output logic            ResvErr,
    input  logic            ErrClr
);

    localparam int unsigned Depth = 2 ** D;

    logic [W-1:0] regs [Depth];
    logic         wr_ok;

    // Writes to R0 vanish when it is hard-wired to zero.
    assign wr_ok = WriteEn && !(ZERO_R0 != 0 && Waddr == '0);

    // Data array; reset loads the preload constants (R0 forced to 0 if hard-wired).
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < Depth; i++) begin
                regs[i] <= (ZERO_R0 != 0 && i == 0) ? '0 : W'(INIT[i]);
            end
        end else if (wr_ok) begin
            regs[Waddr] <= DataIn;
        end
    end

    rf_scoreboard #(
        .D       (D),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (Clk),
        .reset_n   (ResetN),
        .write_en  (WriteEn),
        .waddr     (Waddr),
        .resv_en   (ResvEn),
        .resv_addr (ResvAddr),
        .err_clr   (ErrClr),
        .busy      (Busy),
        .resv_err  (ResvErr)
    );

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [D-1:0] ra;
        logic         hit;

        assign ra  = D'(port_field(128'(Raddr), g, D));
        // Same-cycle write forwards its data and satisfies any pending reservation.
        assign hit = wr_ok && (Waddr == ra);

        assign DataOut[g*W +: W] = hit ? DataIn : regs[ra];
        assign RdReady[g]        = !Busy[ra] || hit;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with NR combinational read ports, one write port, write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard lets the controller reserve a destination register for a multi-cycle unit (e.g. a multiplier/LFSR engine) and detect read-after-write hazards.
- Reset loads per-register preload constants supplied by parameter.
- Sits in the datapath between the decoder/controller and the ALU; successor to the fixed two-port register file.

Parameters:
- W, 8, data width in bits.
- D, 4, address width; depth is 2**D.
- NR, 2, number of read ports (1..4).
- ZERO_R0, 0, when 1 register 0 reads as 0, ignores writes and is never busy.
- INIT, all-zero array of 2**D W-bit values, reset value per register (type from regfile_pkg).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous active-low reset.
- WriteEn  in  1  write strobe.
- Waddr  in  D  write address.
- DataIn  in  W  write data.
- Raddr  in  NR*D  packed read addresses; port i uses bits [i*D +: D].
- DataOut  out  NR*W  packed read data, combinational.
- RdReady  out  NR  per read port: 1 = register not busy, or being written this cycle.
- ResvEn  in  1  reserve strobe: marks ResvAddr busy.
- ResvAddr  in  D  register to reserve.
- Busy  out  2**D  busy bit vector, registered.
- ResvErr  out  1  sticky: a reserve targeted an already-busy register.
- ErrClr  in  1  clears ResvErr.

Behaviour:
- Reset (ResetN=0, async): Registers[i]<=INIT[i]; Busy<=0; ResvErr<=0. With ZERO_R0=1, register 0 stays 0 regardless of INIT[0].
- While in reset, DataOut shows INIT values and RdReady is all 1. A reset asserted mid-reservation drops every pending reservation.
- Write: on posedge with WriteEn=1, Registers[Waddr]<=DataIn and Busy[Waddr]<=0. Writes to R0 are discarded when ZERO_R0=1.
- Read (0 cycles latency):
  - DataOut[i] = DataIn if WriteEn && Waddr==Raddr[i] (bypass, except R0 when ZERO_R0=1); otherwise Registers[Raddr[i]].
  - All NR ports are independent; identical addresses on several ports are legal.
- RdReady[i] = !Busy[Raddr[i]] || (WriteEn && Waddr==Raddr[i]).
- Reserve: on posedge with ResvEn=1, Busy[ResvAddr]<=1.
  - If Busy[ResvAddr] was already 1 and no write to that address occurs in the same cycle, ResvErr<=1.
  - Reserve of R0 with ZERO_R0=1 is ignored.
- Simultaneous write and reserve to the same address: the write updates data; Busy ends at 1 (the new reservation wins); no error.
- ResvErr: set wins over ErrClr in the same cycle. Otherwise ErrClr=1 clears it on the next edge.
- Writing a non-busy register is legal; Busy stays 0.
- Widths: no arithmetic. Out-of-range addresses cannot occur (the array is exactly 2**D deep).

Decomposition:
- regfile_pkg:
  - typedef for the INIT array (logic [W-1:0] [2**D]; default package W=8, D=4).
  - constant DEFAULT_INIT with R0=30 and R2=5.
  - helper function to slice packed port vectors.
- One sub-module, rf_scoreboard:
  - holds Busy and ResvErr.
  - inputs: WriteEn/Waddr, ResvEn/ResvAddr, ErrClr.
  - reused later by the memory-port interlock.
- Data array, bypass muxes and generate-loop read ports stay in reg_file_sb.

Test Plan:
- Reset with INIT=DEFAULT_INIT, ResetN pulsed low mid-cycle -> immediately R0 reads 30 (0x1E), R2 reads 5, others 0; Busy=0, ResvErr=0.
- Write R3=0xA5 with Raddr[0]=3 in the same cycle -> DataOut[0]=0xA5 combinationally; after the edge still 0xA5; port 1 reading R3 also 0xA5.
- ResvEn R5 -> next cycle Busy[5]=1, RdReady for R5 = 0. Cycle of WriteEn R5=0x3C -> RdReady=1 and DataOut=0x3C; after the edge Busy[5]=0.
- Reserve R7 twice without a write -> ResvErr=1 after the second edge. ErrClr -> 0 next edge. ErrClr concurrent with a new double-reserve -> ResvErr stays 1.
- Write and reserve R4 in the same cycle while R4 is busy -> R4 holds the new data, Busy[4]=1, ResvErr unchanged.
- ZERO_R0=1, NR=3: write R0=0xFF and reserve R0 -> all ports reading R0 return 0, RdReady=1, Busy[0]=0. Assert ResetN low while R6 is busy -> Busy[6]=0 asynchronously.
